sample_capture_bank: RTL and testbench
======================================

# sample_capture_bank

Parametrised multi-bank capture buffer for the frequency-counter datapath. It writes qualified samples (`signal_in` with `mem_valid`) into NUM_BANKS ping-pong RAM banks of 2^ADDR_W words each, and flags each bank ready when it fills. A downstream reader pulls data through a registered read port and returns each bank with a release handshake. It supports continuous and one-shot capture, and counts samples dropped while no bank is free.

## Interface
- DATA_W, default 10: sample width.
- ADDR_W, default 16: address width; depth per bank = 2^ADDR_W.
- NUM_BANKS, default 2: number of banks, ≥2. BANK_W = max(1, clog2(NUM_BANKS)).
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- mem_valid, input, 1: `signal_in` is a valid sample this cycle.
- signal_in, input, DATA_W: sample data.
- arm, input, 1: one-cycle pulse that starts or restarts a capture.
- one_shot, input, 1: sampled on `arm`. 1 = stop after one bank; 0 = continuous.
- rd_en, input, 1: read request.
- rd_bank, input, BANK_W: bank to read.
- rd_addr, input, ADDR_W: word to read.
- rd_data, output, DATA_W: read data.
- rd_valid, output, 1: `rd_data` is valid.
- release, input, 1: one-cycle pulse returning bank `release_bank` to the free pool.
- release_bank, input, BANK_W: bank being released.
- bank_ready, output, NUM_BANKS: per-bank "full, awaiting release" flags.
- wr_bank, output, BANK_W: bank currently being written.
- busy, output, 1: high in CAPTURE or WAIT_FREE.
- done, output, 1: high in DONE.
- drop_cnt, output, 16: saturating count of dropped samples.

## Operation
- States:
  - IDLE: after reset; ignores samples.
  - CAPTURE: accepting samples.
  - WAIT_FREE: next bank still ready; samples are dropped.
  - DONE: one-shot capture complete.
- `arm`, accepted in any state:
  - wr_addr := 0, wr_bank := 0, bank_ready := 0, drop_cnt := 0.
  - Latches `one_shot`; state := CAPTURE.
  - A sample presented in the arm cycle is ignored and not counted.
  - `arm` has priority over every other event in that cycle.
- CAPTURE, `mem_valid` = 1: write `signal_in` to [wr_bank][wr_addr], then wr_addr++.
- Bank fill: the accepted write has wr_addr = 2^ADDR_W − 1. In that cycle:
  - bank_ready[wr_bank] sets.
  - wr_addr wraps to 0.
  - If one-shot: state := DONE; wr_bank is unchanged.
  - Otherwise: nb = (wr_bank + 1) mod NUM_BANKS; wr_bank := nb.
    - If bank_ready[nb] is clear, or is being released this cycle: stay in CAPTURE.
    - Otherwise: state := WAIT_FREE.
- WAIT_FREE:
  - Each `mem_valid` cycle increments drop_cnt, saturating at 65535.
  - A release of wr_bank moves the state to CAPTURE on that edge. A sample in the release cycle is dropped.
- `release` clears bank_ready[release_bank]:
  - Valid in any state.
  - Releasing a non-ready bank is a no-op.
  - Release and fill of different banks in the same cycle both take effect.
- Read port:
  - Independent of state; reads any bank at any time.
  - Reading the bank being written returns the old content at that address; read-during-write is old-data.
- DONE: holds until `arm`. Banks remain readable and releasable.
- Storage: inferred synchronous RAM, one array of NUM_BANKS·2^ADDR_W words addressed by {bank, addr}. RAM contents are not reset.

## Timing
- Reset values: state = IDLE; wr_addr = 0; wr_bank = 0; bank_ready = 0; busy = 0; done = 0; drop_cnt = 0; rd_valid = 0; rd_data = 0.
- Write latency: 0. The sample is written on the edge where `mem_valid` = 1 in CAPTURE.
- Flag timing: bank_ready, wr_bank, busy and done are registered and update the cycle after the causing edge.
- Bank switch is gapless. In continuous mode with a free next bank, a sample in the cycle after a fill goes to word 0 of the new bank.
- Read latency: 1. Request on edge N gives rd_data/rd_valid after edge N+1. rd_valid = registered rd_en; rd_data holds its value when rd_valid = 0.
- Asynchronous reset mid-capture aborts immediately to IDLE. Captured data is not guaranteed.

## Test plan
Parameters for all scenarios: DATA_W=10, ADDR_W=3, NUM_BANKS=2 unless noted.
- **Reset/idle.** Assert rst_n=0 mid-stream, then drive 5 valid samples with no arm. Required: all outputs at reset values; bank_ready=00; busy=0.
- **Continuous ping-pong.** arm with one_shot=0, then drive 16 back-to-back samples 0..15. Required: bank_ready=01 one cycle after sample 7 and 11 after sample 15; wr_bank toggles 0→1→0. Reading bank1 addr 3 gives 11 exactly one cycle after rd_en.
- **Overflow.** From the previous end state, with no release, drive 4 samples. Required: state WAIT_FREE, drop_cnt=4. Then release bank0 and drive 1 sample in the release cycle and 2 after. Required: drop_cnt=5; bank0 addr0 = 1st post-release sample.
- **One-shot.** arm with one_shot=1, then 10 samples. Required: done=1 after the 8th sample; samples 9-10 not written, drop_cnt=0; bank_ready=01; wr_bank=0.
- **Simultaneous events.** Release bank1 on the same cycle bank0 fills. Required: bank_ready=01, state stays CAPTURE. Then arm during CAPTURE at wr_addr=5. Required: wr_addr=0, bank_ready=00, drop_cnt=0 next cycle.
- **Parameter sweep.** NUM_BANKS=3, ADDR_W=2, continuous, 12 samples, no release. Required: bank_ready=111, state WAIT_FREE, wr_bank=0.

Source files
------------

// File: rtl/sample_capture_bank.sv
// sample_capture_bank: multi-bank ping-pong capture buffer with a registered read port.
// release_req is the bank-return pulse ("release" is a reserved word in SystemVerilog).
module sample_capture_bank #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned BANK_W   = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_valid,
  input  logic [DATA_W-1:0]    signal_in,
  input  logic                 arm,
  input  logic                 one_shot,
  input  logic                 rd_en,
  input  logic [BANK_W-1:0]    rd_bank,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 release_req,
  input  logic [BANK_W-1:0]    release_bank,
  output logic [NUM_BANKS-1:0] bank_ready,
  output logic [BANK_W-1:0]    wr_bank,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned       Depth     = NUM_BANKS * (2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] LastAddr  = '1;
  localparam logic [BANK_W-1:0] LastBank  = BANK_W'(NUM_BANKS - 1);
  localparam logic [BANK_W:0]   NumBanksW = (BANK_W + 1)'(NUM_BANKS);

  typedef enum logic [1:0] {StIdle, StCapture, StWaitFree, StDone} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [BANK_W-1:0]    wr_bank_q, wr_bank_d;
  logic [NUM_BANKS-1:0] bank_ready_q, bank_ready_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 one_shot_q, one_shot_d;
  logic                 wr_en;
  logic [NUM_BANKS-1:0] rel_mask;
  logic [BANK_W-1:0]    next_bank;
  logic                 rd_bank_ok;
  logic [DATA_W-1:0]    rd_data_q;
  logic                 rd_valid_q;

  logic [DATA_W-1:0]    mem [Depth];

  always_comb begin
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      rel_mask[i] = release_req && (release_bank == BANK_W'(i));
    end
  end

  assign next_bank  = (wr_bank_q == LastBank) ? '0 : wr_bank_q + 1'b1;
  assign rd_bank_ok = {1'b0, rd_bank} < NumBanksW;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    wr_bank_d    = wr_bank_q;
    bank_ready_d = bank_ready_q & ~rel_mask;
    drop_cnt_d   = drop_cnt_q;
    one_shot_d   = one_shot_q;
    wr_en        = 1'b0;
    if (arm) begin
      // Arm overrides any release, fill or sample in the same cycle.
      state_d      = StCapture;
      wr_addr_d    = '0;
      wr_bank_d    = '0;
      bank_ready_d = '0;
      drop_cnt_d   = '0;
      one_shot_d   = one_shot;
    end else begin
      case (state_q)
        StCapture: begin
          if (mem_valid) begin
            wr_en     = 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_addr_q == LastAddr) begin
              bank_ready_d[wr_bank_q] = 1'b1;
              if (one_shot_q) begin
                state_d = StDone;
              end else begin
                wr_bank_d = next_bank;
                // A bank released on this very edge counts as free.
                if (bank_ready_q[next_bank] && !rel_mask[next_bank]) begin
                  state_d = StWaitFree;
                end
              end
            end
          end
        end
        StWaitFree: begin
          if (mem_valid && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
          if (rel_mask[wr_bank_q]) begin
            state_d = StCapture;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wr_addr_q    <= '0;
      wr_bank_q    <= '0;
      bank_ready_q <= '0;
      drop_cnt_q   <= '0;
      one_shot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      wr_bank_q    <= wr_bank_d;
      bank_ready_q <= bank_ready_d;
      drop_cnt_q   <= drop_cnt_d;
      one_shot_q   <= one_shot_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank_q, wr_addr_q}] <= signal_in;
    end
  end

  // Same-edge read of a location being written returns the previous content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_bank_ok ? mem[{rd_bank, rd_addr}] : '0;
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign bank_ready = bank_ready_q;
  assign wr_bank    = wr_bank_q;
  assign busy       = (state_q == StCapture) || (state_q == StWaitFree);
  assign done       = (state_q == StDone);
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_sample_capture_bank.sv
// Scoreboarded random/directed bench for sample_capture_bank against a behavioural model.
module tb_sample_capture_bank;
  localparam int DW    = 10;
  localparam int AW    = 3;
  localparam int NB    = 2;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_valid = 1'b0;
  logic [DW-1:0] signal_in = '0;
  logic          arm = 1'b0;
  logic          one_shot = 1'b0;
  logic          rd_en = 1'b0;
  logic [0:0]    rd_bank = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          release_req = 1'b0;
  logic [0:0]    release_bank = '0;
  logic [NB-1:0] bank_ready;
  logic [0:0]    wr_bank;
  logic          busy;
  logic          done;
  logic [15:0]   drop_cnt;

  // Second configuration: three banks of four words.
  logic          s_mem_valid = 1'b0;
  logic [DW-1:0] s_signal_in = '0;
  logic          s_arm = 1'b0;
  logic          s_rd_en = 1'b0;
  logic [1:0]    s_rd_bank = '0;
  logic [1:0]    s_rd_addr = '0;
  logic [DW-1:0] s_rd_data;
  logic          s_rd_valid;
  logic [2:0]    s_bank_ready;
  logic [1:0]    s_wr_bank;
  logic          s_busy;
  logic          s_done;
  logic [15:0]   s_drop_cnt;

  sample_capture_bank #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .signal_in(signal_in), .arm(arm),
    .one_shot(one_shot), .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .release_req(release_req),
    .release_bank(release_bank), .bank_ready(bank_ready), .wr_bank(wr_bank), .busy(busy),
    .done(done), .drop_cnt(drop_cnt)
  );

  sample_capture_bank #(.DATA_W(DW), .ADDR_W(2), .NUM_BANKS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mem_valid(s_mem_valid), .signal_in(s_signal_in), .arm(s_arm),
    .one_shot(1'b0), .rd_en(s_rd_en), .rd_bank(s_rd_bank), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .release_req(1'b0), .release_bank(2'd0),
    .bank_ready(s_bank_ready), .wr_bank(s_wr_bank), .busy(s_busy), .done(s_done),
    .drop_cnt(s_drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 idle, 1 capture, 2 wait-free, 3 done.
  int m_state, m_bank, m_addr, m_drop;
  bit m_os;
  bit m_ready [NB];
  int m_mem   [NB][DEPTH];
  bit m_wr    [NB][DEPTH];
  int exp_q[$];
  int last_rd;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ready_mask();
    int m = 0;
    for (int i = 0; i < NB; i++) if (m_ready[i]) m += (1 << i);
    return m;
  endfunction

  task automatic model_reset();
    m_state = 0; m_bank = 0; m_addr = 0; m_drop = 0; m_os = 0;
    for (int b = 0; b < NB; b++) begin
      m_ready[b] = 0;
      for (int a = 0; a < DEPTH; a++) m_wr[b][a] = 0;
    end
    exp_q.delete();
    last_rd = 0;
  endtask

  task automatic model_step(bit v, int d, bit a, bit os, bit rel, int rb);
    int st;
    if (a) begin
      m_state = 1; m_bank = 0; m_addr = 0; m_drop = 0; m_os = os;
      for (int i = 0; i < NB; i++) m_ready[i] = 0;
      return;
    end
    st = m_state;
    if (rel) m_ready[rb] = 0;
    if (st == 1 && v) begin
      m_mem[m_bank][m_addr] = d;
      m_wr[m_bank][m_addr]  = 1;
      if (m_addr == DEPTH - 1) begin
        m_ready[m_bank] = 1;
        m_addr = 0;
        if (m_os) m_state = 3;
        else begin
          m_bank = (m_bank + 1) % NB;
          if (m_ready[m_bank]) m_state = 2;
        end
      end else begin
        m_addr++;
      end
    end else if (st == 2) begin
      if (v && m_drop < 65535) m_drop++;
      if (rel && rb == m_bank) m_state = 1;
    end
  endtask

  task automatic check_status();
    check("bank_ready", int'(bank_ready), ready_mask());
    check("wr_bank", int'(wr_bank), m_bank);
    check("busy", int'(busy), (m_state == 1 || m_state == 2) ? 1 : 0);
    check("done", int'(done), (m_state == 3) ? 1 : 0);
    check("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  // Inputs change at a falling edge; outputs are checked at the following falling edge.
  task automatic step(bit v, int d, bit a = 0, bit os = 0, bit rel = 0, int rb = 0,
                      bit rd = 0, int rdb = 0, int rda = 0);
    mem_valid = v; signal_in = DW'(d); arm = a; one_shot = os;
    release_req = rel; release_bank = 1'(rb);
    rd_en = rd; rd_bank = 1'(rdb); rd_addr = AW'(rda);
    if (rd) exp_q.push_back(m_mem[rdb][rda]);
    model_step(v, d, a, os, rel, rb);
    @(posedge clk);
    @(negedge clk);
    check_status();
  endtask

  // Read monitor: pops the scoreboard whenever rd_valid is presented.
  always @(negedge clk) begin
    int e;
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rd_unexpected: rd_valid with nothing pending, rd_data=%0d", rd_data);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", int'(rd_data), e);
          last_rd = e;
        end
      end else begin
        check("rd_hold", int'(rd_data), last_rd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, ad;
    bit rd;
    model_reset();
    repeat (2) @(negedge clk);
    check_status();
    check("rd_valid_rst", int'(rd_valid), 0);
    check("rd_data_rst", int'(rd_data), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 7 + i);

    // Continuous ping-pong.
    step(0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, i);
    step(0, 0, .rd(1), .rdb(1), .rda(3));
    check("pingpong_rd_valid", int'(rd_valid), 1);
    check("pingpong_rd_data", int'(rd_data), 11);

    // Overflow then release of bank 0 with a sample in the release cycle.
    for (int i = 0; i < 4; i++) step(1, 100 + i);
    step(1, 200, .rel(1), .rb(0));
    step(1, 201);
    step(1, 202);
    step(0, 0, .rd(1), .rdb(0), .rda(0));
    step(0, 0);

    // One-shot.
    step(0, 0, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 300 + i);
    step(0, 0, .rd(1), .rdb(0), .rda(7));
    step(0, 0, .rd(1), .rdb(1), .rda(0));
    step(0, 0);

    // Release of one bank while the other fills, then re-arm mid-bank.
    step(0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 400 + i);
    step(1, 408, .rel(1), .rb(0));
    for (int i = 1; i < 8; i++) step(1, 408 + i);
    for (int i = 0; i < 7; i++) step(1, 416 + i);
    step(1, 423, .rel(1), .rb(1));
    for (int i = 0; i < 5; i++) step(1, 424 + i);
    step(1, 999, 1, 0);
    step(1, 500);
    step(0, 0, .rd(1), .rdb(0), .rda(0));
    step(0, 0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rd = 0; b = 0; ad = 0;
      if ($urandom % 3 == 0) begin
        for (int t = 0; t < 4; t++) begin
          b  = int'($urandom % NB);
          ad = int'($urandom % DEPTH);
          if (m_wr[b][ad]) begin
            rd = 1;
            break;
          end
        end
        if (!rd) begin
          b = 0;
          ad = 0;
        end
      end
      step($urandom % 4 != 0, int'($urandom % 1024), $urandom % 60 == 0, $urandom % 3 == 0,
           $urandom % 6 == 0, int'($urandom % NB), rd, b, ad);
    end

    // Asynchronous reset mid-capture, then samples without arm are ignored.
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 600 + i);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_status();
    check("rd_valid_async_rst", int'(rd_valid), 0);
    check("rd_data_async_rst", int'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1, 700 + i);

    // Three banks of four words, no release.
    s_arm = 1'b1;
    @(negedge clk);
    s_arm = 1'b0;
    for (int k = 0; k < 12; k++) begin
      s_mem_valid = 1'b1;
      s_signal_in = DW'(50 + k);
      @(negedge clk);
    end
    s_mem_valid = 1'b0;
    check("sweep_bank_ready", int'(s_bank_ready), 7);
    check("sweep_busy", int'(s_busy), 1);
    check("sweep_done", int'(s_done), 0);
    check("sweep_wr_bank", int'(s_wr_bank), 0);
    check("sweep_drop0", int'(s_drop_cnt), 0);
    s_mem_valid = 1'b1;
    s_signal_in = DW'(900);
    s_rd_en = 1'b1; s_rd_bank = 2'd2; s_rd_addr = 2'd1;
    @(negedge clk);
    s_mem_valid = 1'b0;
    s_rd_en = 1'b0;
    check("sweep_drop1", int'(s_drop_cnt), 1);
    check("sweep_rd_valid", int'(s_rd_valid), 1);
    check("sweep_rd_data", int'(s_rd_data), 59);

    step(0, 0);
    step(0, 0);
    check("rd_pending", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
